// File: rtl/u22_char_if.sv
// u22_char_if: bus between the u22_char characteriser and its controller / gate under test.
// Optional compare signals exist only when U22_CHAR_CHECK_EN is defined.
interface u22_char_if #(
    parameter int unsigned NPINS = 6
) ();
    logic               wr_en;
    logic [2:0]         wr_pin;
    logic [2:0]         wr_data;
    logic               start;
    logic               busy;
    logic               done;
    logic [3:0]         func1;
    logic [3:0]         func2;
    logic [3*NPINS-1:0] dut_wiring;
    logic [1:0]         dut_in;
    logic [1:0]         dut_out;
`ifdef U22_CHAR_CHECK_EN
    logic [3:0]         exp_func1;
    logic [3:0]         exp_func2;
    logic               match;

    modport master (
        output wr_en, wr_pin, wr_data, start, dut_out, exp_func1, exp_func2,
        input  busy, done, func1, func2, dut_wiring, dut_in, match
    );
    modport slave (
        input  wr_en, wr_pin, wr_data, start, dut_out, exp_func1, exp_func2,
        output busy, done, func1, func2, dut_wiring, dut_in, match
    );
`else
    modport master (
        output wr_en, wr_pin, wr_data, start, dut_out,
        input  busy, done, func1, func2, dut_wiring, dut_in
    );
    modport slave (
        input  wr_en, wr_pin, wr_data, start, dut_out,
        output busy, done, func1, func2, dut_wiring, dut_in
    );
`endif
endinterface

// File: rtl/u22_char.sv
// u22_char: wiring-to-function characteriser for the 2-input/2-output universal gate.
// Holds a per-pin wiring word, sweeps the gate inputs through 00..11 and assembles the two
// output truth tables. Optional expected-value compare is enabled by U22_CHAR_CHECK_EN.
module u22_char #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned NPINS  = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    u22_char_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [3*NPINS-1:0] r_wiring;
    logic [1:0]         r_vec;
    logic [3:0]         r_cnt;
    logic [3:0]         r_sh1;
    logic [3:0]         r_sh2;
    logic [3:0]         r_func1;
    logic [3:0]         r_func2;
    logic               w_start_ok;
    logic               w_sample;
    logic               w_last;

    // A start that coincides with a write is dropped so the wiring is stable before the run.
    assign w_start_ok = (r_state == StIdle) && bus.start && !bus.wr_en;
    assign w_sample   = (r_state == StRun) && (r_cnt == 4'(SETTLE - 1));
    assign w_last     = w_sample && (r_vec == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_start_ok) w_state_nxt = StRun;
            StRun:   if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Wiring word: per-pin writes accepted only while idle; out-of-range pins fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wiring <= '0;
        end else if ((r_state == StIdle) && bus.wr_en) begin
            for (int p = 0; p < int'(NPINS); p++) begin
                if (bus.wr_pin == 3'(p)) begin
                    r_wiring[3*p +: 3] <= bus.wr_data;
                end
            end
        end
    end

    // Sweep counters and shadow truth tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec <= 2'd0;
            r_cnt <= 4'd0;
            r_sh1 <= 4'd0;
            r_sh2 <= 4'd0;
        end else if (w_start_ok) begin
            r_vec <= 2'd0;
            r_cnt <= 4'd0;
        end else if (r_state == StRun) begin
            if (w_sample) begin
                r_cnt        <= 4'd0;
                r_vec        <= r_vec + 2'd1;
                r_sh1[r_vec] <= bus.dut_out[1];
                r_sh2[r_vec] <= bus.dut_out[0];
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Results load with the final sample so they are valid in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func1 <= 4'd0;
            r_func2 <= 4'd0;
        end else if (w_last) begin
            r_func1 <= {bus.dut_out[1], r_sh1[2:0]};
            r_func2 <= {bus.dut_out[0], r_sh2[2:0]};
        end
    end

`ifdef U22_CHAR_CHECK_EN
    logic r_match;
    logic w_match;

    assign w_match = (r_sh1 == bus.exp_func1) && (r_sh2 == bus.exp_func2);

    // Compare result captured from the done cycle and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (r_state == StDone) begin
            r_match <= w_match;
        end
    end
`endif

    // Outputs decoded from state and registers.
    always_comb begin
        bus.busy       = (r_state == StRun);
        bus.done       = (r_state == StDone);
        bus.dut_in     = (r_state == StRun) ? r_vec : 2'b00;
        bus.func1      = r_func1;
        bus.func2      = r_func2;
        bus.dut_wiring = r_wiring;
`ifdef U22_CHAR_CHECK_EN
        // Live compare during done so match is valid alongside the done pulse.
        bus.match      = (r_state == StDone) ? w_match : r_match;
`endif
    end
endmodule

// File: tb/tb_u22_char.sv
// tb_u22_char: directed + randomized bench for u22_char with a truth-table reference model.
// Compare checks are compiled in when U22_CHAR_CHECK_EN is defined.
module tb_u22_char;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NPINS  = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    u22_char_if #(.NPINS(NPINS)) bus ();

    u22_char #(.SETTLE(SETTLE), .NPINS(NPINS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_err    = 0;
    int         n_checks = 0;
    int         gmode    = 0;
    logic [3:0] rtt1     = 4'd0;
    logic [3:0] rtt2     = 4'd0;
    logic [2:0] wmodel [NPINS];
    logic [3:0] hold1    = 4'd0;
    logic [3:0] hold2    = 4'd0;
    logic       hold_m   = 1'b0;

    // Gate under test: mode 0 = {a&b, a^b}, mode 1 = {1, ~a}, mode 2 = random tables.
    always_comb begin
        case (gmode)
            0:       bus.dut_out = {bus.dut_in[1] & bus.dut_in[0], bus.dut_in[1] ^ bus.dut_in[0]};
            1:       bus.dut_out = {1'b1, ~bus.dut_in[1]};
            default: bus.dut_out = {rtt1[bus.dut_in], rtt2[bus.dut_in]};
        endcase
    end

    function automatic logic [1:0] gate_ref(int m, int v, logic [3:0] t1, logic [3:0] t2);
        logic a = v[1];
        logic b = v[0];
        case (m)
            0:       return {a & b, a ^ b};
            1:       return {1'b1, ~a};
            default: return {t1[v], t2[v]};
        endcase
    endfunction

    function automatic logic [3*NPINS-1:0] exp_wiring();
        logic [3*NPINS-1:0] w = '0;
        for (int p = 0; p < int'(NPINS); p++) w[3*p +: 3] = wmodel[p];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_pin(int p, logic [2:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_pin  = 3'(p);
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        if (p < int'(NPINS)) wmodel[p] = d;
        chk("wiring_write", 32'(bus.dut_wiring), 32'(exp_wiring()));
    endtask

    task automatic run(int m, logic [3:0] e1, logic [3:0] e2, bit extra_start, bit wr_during);
        logic [3:0] ef1 = 4'd0;
        logic [3:0] ef2 = 4'd0;
        int         ndone;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] o = gate_ref(m, v, rtt1, rtt2);
            ef1[v] = o[1];
            ef2[v] = o[0];
        end
`ifdef U22_CHAR_CHECK_EN
        bus.exp_func1 = e1;
        bus.exp_func2 = e2;
`else
        if (e1 == e2) ndone = 0;
`endif
        gmode     = m;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= int'(4 * SETTLE); k++) begin
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("done_run", 32'(bus.done), 32'd0);
            chk("dut_in_seq", 32'(bus.dut_in), 32'((k - 1) / int'(SETTLE)));
            chk("func1_hold", 32'(bus.func1), 32'(hold1));
            chk("func2_hold", 32'(bus.func2), 32'(hold2));
            chk("wiring_run", 32'(bus.dut_wiring), 32'(exp_wiring()));
            bus.start = (extra_start && k == 3);
            if (wr_during) begin
                bus.wr_en   = 1'b1;
                bus.wr_pin  = 3'd2;
                bus.wr_data = 3'd7;
            end
            step();
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("func1", 32'(bus.func1), 32'(ef1));
        chk("func2", 32'(bus.func2), 32'(ef2));
        chk("dut_in_done", 32'(bus.dut_in), 32'd0);
        chk("wiring_done", 32'(bus.dut_wiring), 32'(exp_wiring()));
`ifdef U22_CHAR_CHECK_EN
        hold_m = (ef1 == e1) && (ef2 == e2);
        chk("match_done", 32'(bus.match), 32'(hold_m));
`endif
        hold1 = ef1;
        hold2 = ef2;
        step();
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("busy_after", 32'(bus.busy), 32'd0);
`ifdef U22_CHAR_CHECK_EN
        chk("match_held", 32'(bus.match), 32'(hold_m));
`endif
        if (extra_start) begin
            ndone = 0;
            for (int k = 0; k < 12; k++) begin
                if (bus.done) ndone++;
                step();
            end
            chk("no_extra_done", 32'(ndone), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_pin  = 3'd0;
        bus.wr_data = 3'd0;
        bus.start   = 1'b0;
`ifdef U22_CHAR_CHECK_EN
        bus.exp_func1 = 4'd0;
        bus.exp_func2 = 4'd0;
`endif
        for (int p = 0; p < int'(NPINS); p++) wmodel[p] = 3'd0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_func1", 32'(bus.func1), 32'd0);
        chk("rst_func2", 32'(bus.func2), 32'd0);
        chk("rst_wiring", 32'(bus.dut_wiring), 32'd0);
        chk("rst_dut_in", 32'(bus.dut_in), 32'd0);
`ifdef U22_CHAR_CHECK_EN
        chk("rst_match", 32'(bus.match), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load pins 0..5 with codes 1..6; pin 7 must be ignored.
        for (int p = 0; p < 6; p++) write_pin(p, 3'(p + 1));
        chk("wiring_const", 32'(bus.dut_wiring), 32'h358D1);
        write_pin(7, 3'd7);
        chk("wiring_pin7", 32'(bus.dut_wiring), 32'h358D1);

        // Write and start together: write lands, start dropped.
        bus.wr_en   = 1'b1;
        bus.wr_pin  = 3'd0;
        bus.wr_data = 3'd1;
        bus.start   = 1'b1;
        step();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk("wr_start_busy", 32'(bus.busy), 32'd0);
        step();
        chk("wr_start_busy2", 32'(bus.busy), 32'd0);

        run(0, 4'd8, 4'd6, 1'b0, 1'b0);
        run(0, 4'd8, 4'd7, 1'b0, 1'b0);
        run(1, 4'hF, 4'h3, 1'b1, 1'b0);
        run(1, 4'hF, 4'h3, 1'b0, 1'b0);
        run(1, 4'h0, 4'h0, 1'b0, 1'b1);

        // Mid-run reset aborts immediately and clears everything.
        gmode     = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_func1", 32'(bus.func1), 32'd0);
        chk("mid_rst_func2", 32'(bus.func2), 32'd0);
        chk("mid_rst_wiring", 32'(bus.dut_wiring), 32'd0);
        chk("mid_rst_dut_in", 32'(bus.dut_in), 32'd0);
        for (int p = 0; p < int'(NPINS); p++) wmodel[p] = 3'd0;
        hold1  = 4'd0;
        hold2  = 4'd0;
        hold_m = 1'b0;
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done || bus.busy) ndone++;
            step();
        end
        chk("no_done_after_rst", 32'(ndone), 32'd0);
        for (int p = 0; p < 6; p++) write_pin(p, 3'($urandom_range(0, 7)));
        run(0, 4'd8, 4'd6, 1'b0, 1'b0);

        // Randomized wirings and gate tables.
        for (int i = 0; i < 4; i++) begin
            rtt1 = 4'($urandom);
            rtt2 = 4'($urandom);
            for (int j = 0; j < 3; j++) write_pin(int'($urandom_range(0, 7)), 3'($urandom));
            run(2, rtt1, 4'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
